// File: rtl/decoder_5to32.sv
// decoder_5to32: registered 5-to-32 one-hot decoder with enable.
// Used as a chip-select / register-bank write-strobe generator. The output
// word and the valid flag are both registered. The asynchronous active-low
// reset forces the output word to its idle value and clears valid.
// OUT_ACTIVE_LOW inverts the output word: all-ones when idle, and a single
// zero on the selected line.

module decoder_5to32 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  a,
    input  logic        enable,
    output logic [31:0] y,
    output logic        valid
);

    // Value seen on y when no line is selected (reset or enable low)
    localparam logic [31:0] IDLE_WORD = OUT_ACTIVE_LOW ? 32'hFFFF_FFFF : 32'h0000_0000;

    // Active-high one-hot image of a 5-bit select; every select value is legal
    function automatic logic [31:0] decode_onehot(input logic [4:0] sel);
        logic [31:0] v;
        v      = 32'h0000_0000;
        v[sel] = 1'b1;
        return v;
    endfunction

    logic [31:0] w_hot;
    logic [31:0] w_y_next;
    logic [31:0] r_y;
    logic        r_valid;

    // Next-state decode: one-hot when enabled, all lines inactive otherwise
    always_comb begin
        w_hot    = 32'h0000_0000;
        w_y_next = IDLE_WORD;
        if (enable) begin
            w_hot = decode_onehot(a);
        end else begin
            w_hot = 32'h0000_0000;
        end
        if (OUT_ACTIVE_LOW) begin
            w_y_next = ~w_hot;
        end else begin
            w_y_next = w_hot;
        end
    end

    // Output registers: reset clears them immediately, otherwise capture the decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= IDLE_WORD;
            r_valid <= 1'b0;
        end else begin
            r_y     <= w_y_next;
            r_valid <= enable;
        end
    end

    assign y     = r_y;
    assign valid = r_valid;

endmodule

// File: tb/tb_decoder_5to32.sv
// tb_decoder_5to32: scoreboard bench for decoder_5to32.
// Drives an active-high and an active-low instance from the same inputs.
// Each applied vector pushes its expected result into a queue. The entry is
// popped and compared one cycle later, when the registered output appears.

module tb_decoder_5to32;

    logic        clk;
    logic        rst_n;
    logic [4:0]  a;
    logic        enable;
    logic [31:0] y_hi;
    logic        valid_hi;
    logic [31:0] y_lo;
    logic        valid_lo;

    int n_vec;
    int n_err;

    typedef struct {
        logic [31:0] y;
        logic        v;
    } exp_t;

    exp_t sb[$];

    decoder_5to32 #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .enable (enable),
        .y      (y_hi),
        .valid  (valid_hi)
    );

    decoder_5to32 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .enable (enable),
        .y      (y_lo),
        .valid  (valid_lo)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    // Single comparison point: counts the comparison and reports a miscompare
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of the active-high output word
    function automatic logic [31:0] model_y(input logic [4:0] sel, input logic en);
        logic [31:0] one;
        one = 32'h0000_0001;
        return en ? (one << sel) : 32'h0000_0000;
    endfunction

    // Drive one vector, push its expectation, then compare after the next edge.
    // Called at posedge+1 and returns at posedge+1.
    task automatic apply(input logic [4:0] sel, input logic en, input string tag);
        exp_t e;
        a      = sel;
        enable = en;
        e.y    = model_y(sel, en);
        e.v    = en;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_y"},      y_hi,  e.y);
            check_val({tag, "_valid"},  {31'd0, valid_hi}, {31'd0, e.v});
            check_val({tag, "_ylo"},    y_lo,  ~e.y);
            check_val({tag, "_vlo"},    {31'd0, valid_lo}, {31'd0, e.v});
            if (en) begin
                check_val({tag, "_popcnt"}, $countones(y_hi), 32'd1);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b1;
        enable = 1'b1;
        a      = 5'd5;

        // Reset with enable high and a=5: outputs go idle without any clock edge
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_y",   y_hi, 32'h0000_0000);
        check_val("rst_v",   {31'd0, valid_hi}, 32'd0);
        check_val("rst_ylo", y_lo, 32'hFFFF_FFFF);
        // Inputs stay ignored across edges while reset is held
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_hold_y",   y_hi, 32'h0000_0000);
        check_val("rst_hold_ylo", y_lo, 32'hFFFF_FFFF);
        check_val("rst_hold_v",   {31'd0, valid_lo}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        a      = 5'd0;
        @(posedge clk);
        #1;

        // Disabled for 10 cycles
        for (int i = 0; i < 10; i++) begin
            apply(5'd0, 1'b0, "dis");
        end

        // Full sweep, with a reset pulse between edges at a=12
        for (int i = 0; i < 32; i++) begin
            apply(5'(i), 1'b1, "sweep");
            if (i == 12) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_val("midrst_y",   y_hi, 32'h0000_0000);
                check_val("midrst_v",   {31'd0, valid_hi}, 32'd0);
                check_val("midrst_ylo", y_lo, 32'hFFFF_FFFF);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                // This edge captured a=12 again after release
                check_val("postrst_y",   y_hi, 32'h0000_1000);
                check_val("postrst_v",   {31'd0, valid_hi}, 32'd1);
                check_val("postrst_ylo", y_lo, 32'hFFFF_EFFF);
            end
        end

        // Explicit sweep boundaries and active-low example
        apply(5'd0,  1'b1, "a0");
        check_val("a0_const",  y_hi, 32'h0000_0001);
        apply(5'd31, 1'b1, "a31");
        check_val("a31_const", y_hi, 32'h8000_0000);
        apply(5'd3,  1'b1, "lo3");
        check_val("lo3_const", y_lo, 32'hFFFF_FFF7);

        // Enable toggle with a=17
        apply(5'd17, 1'b1, "tog1");
        check_val("tog1_const", y_hi, 32'h0002_0000);
        apply(5'd17, 1'b0, "tog0");
        check_val("tog0_const", y_hi, 32'h0000_0000);
        check_val("tog0_lo",    y_lo, 32'hFFFF_FFFF);
        apply(5'd17, 1'b1, "tog2");
        check_val("tog2_const", y_hi, 32'h0002_0000);

        // Random vectors, including back-to-back changes
        for (int i = 0; i < 40; i++) begin
            apply(5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), "rnd");
        end

        check_val("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_5to32.md
# decoder_5to32

Registered 5-to-32 one-hot decoder with enable. Converts a 5-bit binary select into a 32-bit one-hot output word, for use as a chip-select / register-bank write-strobe generator. Output is registered on the system clock and cleared by the asynchronous active-low reset. When enable is low, no output line is asserted.

## Interface

Parameters:
- `OUT_ACTIVE_LOW`, default 0: when 1, the output `y` and its reset/idle value are bitwise inverted (all-ones idle, single zero selected).

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`: input, 1 bit. Rising-edge system clock.
- `rst_n`: input, 1 bit. Asynchronous active-low reset.
- `a`: input, 5 bits. Binary select, 0..31.
- `enable`: input, 1 bit. Decode enable, active high.
- `y`: output, 32 bits. Registered one-hot decode of `a`.
- `valid`: output, 1 bit. Registered copy of `enable`; high when `y` holds a selected line.

## Operation

- Next-state decode, with polarity for `OUT_ACTIVE_LOW` = 0:
  - `enable` = 1: y_next[i] = 1 when i == a, otherwise 0. Exactly one bit is set.
  - `enable` = 0: y_next = 32'h0000_0000.
- `OUT_ACTIVE_LOW` = 1: y_next is the bitwise inverse of the above. The idle value is 32'hFFFF_FFFF.
- `valid_next` = `enable`.
- All 32 select values are legal. There is no out-of-range case and no wrap logic; `a` is fully 5-bit.
- No internal state beyond the output registers.
- Unknown (X) on `a` while `enable` = 1 is not supported. Behaviour is undefined and the bench must not drive it.

## Timing

- Reset (`rst_n` = 0, asynchronous, no clock required):
  - `y` goes immediately to its idle value: 0, or all-ones if `OUT_ACTIVE_LOW` = 1.
  - `valid` goes to 0.
- Reset is held while `rst_n` = 0; inputs are ignored.
- Reset deassertion: synchronous release is assumed upstream. The first capture occurs on the first rising `clk` edge with `rst_n` = 1.
- Latency: 1 cycle. `a` and `enable` are sampled on the rising edge; `y` and `valid` update on that same edge and are stable for the rest of the cycle.
- `a` changing every cycle: `y` follows with 1-cycle lag, one new line per cycle, with no glitch-free requirement inside the cycle beyond register outputs.
- `enable` dropping: `y` goes idle and `valid` goes to 0 on the next edge, regardless of `a`.
- `enable` rising: the line for the `a` sampled on the same edge is asserted on that edge.
- Reset mid-operation: `y` and `valid` clear asynchronously at the falling edge of `rst_n`, overriding any pending decode.

## Test plan

- Reset: assert `rst_n` = 0 with `enable` = 1, `a` = 5 -> immediately `y` = 32'h0, `valid` = 0, with no clock edge required.
- Disabled: `rst_n` = 1, `enable` = 0, `a` = 0 held for 10 cycles -> `y` = 32'h0, `valid` = 0 every cycle.
- Full sweep: `enable` = 1, `a` stepped 0..31, one value per cycle -> one cycle after each step, `y` = 1 << a (a=0 -> 32'h0000_0001; a=31 -> 32'h8000_0000). `valid` = 1 throughout. Check popcount(`y`) = 1 each cycle.
- Enable toggle: `a` = 17 with `enable` 1 -> 0 -> 1 on consecutive cycles -> `y` = 32'h0002_0000, then 32'h0, then 32'h0002_0000. `valid` = 1, 0, 1.
- Reset mid-sweep: during the sweep at `a` = 12, pulse `rst_n` low between edges -> `y` clears to 0 at once. After release, the next edge gives `y` = 1 << a of the currently applied `a`.
- Active-low variant: `OUT_ACTIVE_LOW` = 1, `enable` = 1, `a` = 3 -> `y` = 32'hFFFF_FFF7. With `enable` = 0 or in reset -> `y` = 32'hFFFF_FFFF.
